// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with whole-scan debounce,
// ghost rejection and a valid/ack key handshake.
module keypad_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [3:0] KEYCODE,
    output logic       KEY_VALID,
    input  logic       KEY_ACK,
    output logic       KEY_DOWN,
    output logic       KEY_OVR
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [3:0]    r_sync1, r_sync2, r_row, r_cand, r_n, r_keycode;
    logic [1:0]    r_ridx, r_state;
    logic [DW-1:0] r_dwell;
    logic [11:0]   r_cap;
    logic          r_valid, r_down, r_ovr;

    logic        w_row_end, w_scan_end, w_hit, w_match, w_accept, w_release_done;
    logic [15:0] w_low;
    logic [4:0]  w_cnt;
    logic [3:0]  w_key, w_n1, w_cand_n, w_n_n;
    logic [1:0]  w_state_n;

    assign w_row_end  = r_dwell == LAST;
    assign w_scan_end = w_row_end && r_ridx == 2'd3;
    // Row 3 is never stored: its live synchronized columns complete the scan.
    assign w_low      = ~{r_sync2, r_cap};
    assign w_hit      = w_cnt == 5'd1;
    assign w_match    = w_hit && w_key == r_cand;
    assign w_n1       = r_n + 4'd1;
    assign w_accept   = w_scan_end && r_state == S_CONFIRM && w_match && w_n1 == DB;
    assign w_release_done = w_scan_end && r_state == S_RELEASE && !w_match && w_n1 == DB;

    always_comb begin
        w_cnt = '0;
        w_key = '0;
        for (int i = 0; i < 16; i++)
            if (w_low[i]) begin
                w_cnt = w_cnt + 5'd1;
                w_key = 4'(i);
            end
    end

    always_comb begin
        w_state_n = r_state;
        w_cand_n  = r_cand;
        w_n_n     = r_n;
        if (w_scan_end)
            case (r_state)
                S_IDLE: if (w_hit) begin
                    w_state_n = S_CONFIRM;
                    w_cand_n  = w_key;
                    w_n_n     = 4'd1;
                end
                S_CONFIRM:
                    if (!w_match) w_state_n = S_IDLE;
                    else if (w_n1 == DB) w_state_n = S_HELD;
                    else w_n_n = w_n1;
                S_HELD: if (!w_match) begin
                    w_state_n = S_RELEASE;
                    w_n_n     = 4'd1;
                end
                default:
                    if (w_match) w_state_n = S_HELD;
                    else if (w_n1 == DB) w_state_n = S_IDLE;
                    else w_n_n = w_n1;
            endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_row     <= 4'b1110;
            r_ridx    <= '0;
            r_dwell   <= '0;
            r_cap     <= '1;
            r_state   <= S_IDLE;
            r_cand    <= '0;
            r_n       <= '0;
            r_keycode <= '0;
            r_valid   <= 1'b0;
            r_down    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_sync1 <= COL;
            r_sync2 <= r_sync1;
            r_dwell <= w_row_end ? '0 : r_dwell + DW'(1);
            if (w_row_end) begin
                r_ridx <= r_ridx + 2'd1;
                r_row  <= {r_row[2:0], r_row[3]};
            end
            for (int i = 0; i < 3; i++)
                if (w_row_end && r_ridx == 2'(i)) r_cap[i*4 +: 4] <= r_sync2;
            r_state <= w_state_n;
            r_cand  <= w_cand_n;
            r_n     <= w_n_n;
            if (w_accept) r_keycode <= r_cand;
            r_valid <= w_accept | (r_valid & ~KEY_ACK);
            r_ovr   <= w_accept & r_valid;
            r_down  <= w_accept | (r_down & ~w_release_done);
        end
    end

    assign ROW       = r_row;
    assign KEYCODE   = r_keycode;
    assign KEY_VALID = r_valid;
    assign KEY_DOWN  = r_down;
    assign KEY_OVR   = r_ovr;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized + directed bench for keypad_scan; a scan-level
// reference model queues expected acceptances that a monitor checks.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0, rst = 1'b0, KEY_ACK = 1'b0;
    logic [3:0] COL, ROW, KEYCODE;
    logic       KEY_VALID, KEY_DOWN, KEY_OVR;
    logic [15:0] mask = '0;
    int checks = 0, fails = 0, cyc = 0;

    typedef struct { logic [3:0] key; logic ovr; int at; } exp_t;
    exp_t q[$];
    exp_t e;
    int   m_run = 0, m_miss = 0, m_cand = 0;
    bit   m_down = 0, m_v = 0;
    logic prev_v = 1'b0;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .rst(rst), .COL(COL), .ROW(ROW), .KEYCODE(KEYCODE),
        .KEY_VALID(KEY_VALID), .KEY_ACK(KEY_ACK), .KEY_DOWN(KEY_DOWN), .KEY_OVR(KEY_OVR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pressed key k pulls column k%4 low while its row k/4 is driven.
    always_comb begin
        COL = 4'hF;
        for (int k = 0; k < 16; k++)
            if (mask[k] && !ROW[k/4]) COL[k%4] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if ((KEY_VALID && !prev_v) || KEY_OVR) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_accept: got key %0d at cycle %0d, expected none", KEYCODE, cyc);
            end else begin
                e = q.pop_front();
                chk("keycode", KEYCODE, e.key);
                chk("key_ovr", KEY_OVR, e.ovr);
                chk("accept_cycle", cyc, e.at);
            end
        end
        prev_v = KEY_VALID;
    end

    // One full scan with a fixed set of pressed keys; optional mid-scan ack.
    task automatic scan(input logic [15:0] m, input bit a);
        int res = -1, cnt = 0;
        bit acc = 0;
        for (int k = 0; k < 16; k++)
            if (m[k]) begin
                cnt++;
                res = k;
            end
        if (cnt != 1) res = -1;
        if (a) m_v = 0;
        if (!m_down) begin
            if (m_run == 0) begin
                if (res >= 0) begin
                    m_cand = res;
                    m_run  = 1;
                end
            end else if (res == m_cand) begin
                m_run++;
                if (m_run == DB) begin
                    acc    = 1;
                    m_down = 1;
                    m_miss = 0;
                end
            end else m_run = 0;
        end else if (res == m_cand) m_miss = 0;
        else begin
            m_miss++;
            if (m_miss == DB) begin
                m_down = 0;
                m_run  = 0;
            end
        end
        if (acc) begin
            q.push_back('{key: 4'(m_cand), ovr: m_v, at: cyc + 4 * SD});
            m_v = 1;
        end
        mask = m;
        for (int i = 0; i < 4 * SD; i++) begin
            @(posedge clk);
            #1;
            if (a && i == 7) KEY_ACK = 1'b1;
            if (a && i == 8) begin
                KEY_ACK = 1'b0;
                chk("ack_clears_valid", KEY_VALID, 0);
            end
        end
        chk("key_down", KEY_DOWN, m_down);
        chk("key_valid", KEY_VALID, m_v);
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        chk("rst_row", ROW, 4'b1110);
        chk("rst_down", KEY_DOWN, 0);
        chk("rst_valid", KEY_VALID, 0);
        m_down = 0;
        m_run  = 0;
        m_miss = 0;
        m_v    = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0]  er;
        logic [15:0] rm;
        int hold;
        #12;
        chk("reset_row", ROW, 4'b1110);
        chk("reset_keycode", KEYCODE, 0);
        chk("reset_valid", KEY_VALID, 0);
        chk("reset_down", KEY_DOWN, 0);
        chk("reset_ovr", KEY_OVR, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            er = ~(4'b0001 << ((i / SD) % 4));
            chk("row_rotation", ROW, er);
            if (i % 8 == 0) chk("idle_outputs", {KEY_VALID, KEY_DOWN, KEY_OVR, KEYCODE}, 0);
        end
        repeat (6) @(posedge clk);
        #2;
        chk("row_before_async", ROW, 4'b1101);
        async_reset();

        repeat (3) scan(16'h0040, 0);
        scan(16'h0040, 1);
        scan(16'h0040, 0);
        repeat (3) scan(16'h0000, 0);

        foreach (rm[i]) rm[i] = 1'b0;
        scan(16'h0040, 0); scan(16'h0040, 0); scan(16'h0000, 0);
        scan(16'h0040, 0); scan(16'h0040, 0);
        repeat (3) scan(16'h0000, 0);

        repeat (5) scan(16'h8001, 0);
        repeat (3) scan(16'h0001, 0);
        scan(16'h0000, 1);
        repeat (2) scan(16'h0000, 0);

        repeat (3) scan(16'h0040, 0);
        repeat (3) scan(16'h0000, 0);
        repeat (3) scan(16'h0200, 0);
        scan(16'h0000, 1);
        repeat (2) scan(16'h0000, 0);

        repeat (3) scan(16'h0040, 0);
        repeat (5) @(posedge clk);
        #2;
        async_reset();
        repeat (3) scan(16'h0040, 0);
        scan(16'h0000, 1);
        repeat (2) scan(16'h0000, 0);

        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0: rm = '0;
                3: rm = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                default: rm = 16'h1 << $urandom_range(0, 15);
            endcase
            hold = $urandom_range(1, 5);
            for (int h = 0; h < hold; h++) scan(rm, $urandom_range(0, 2) == 0);
        end
        scan(16'h0000, 1);
        repeat (3) scan(16'h0000, 0);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanner for a 4x4 matrix keypad, the input counterpart of the board's time-multiplexed 7-segment display driver. It strobes one active-low row at a time in the same 1110/1101/1011/0111 rotation the display uses for its digit selects, and samples the four column lines for each row. The block debounces the result over whole scans and hands one 4-bit key code per press to the control logic through a valid/ack handshake.

## Interface
- SCAN_DIV, default 1000: clock cycles each row is driven; legal range ≥ 4.
- DEBOUNCE_SCANS, default 4: consecutive identical full scans needed to accept a press or a release; legal range 2..15.

- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- COL  input  4  raw column pins, active-low (pulled up), asynchronous to clk.
- ROW  output  4  row drive, active-low, registered; exactly one bit low.
- KEYCODE  output  4  accepted key, row*4 + col.
- KEY_VALID  output  1  new key available; held until acknowledged.
- KEY_ACK  input  1  consumer acknowledge; clears KEY_VALID.
- KEY_DOWN  output  1  level, debounced key currently held.
- KEY_OVR  output  1  one-cycle pulse: a new key was accepted while KEY_VALID was still high.

## Operation
- COL passes through a 2-flop synchronizer (colS).
- Row index r (0..3) and dwell counter d (0..SCAN_DIV-1) are free-running. ROW = ~(1<<r).
- At d == SCAN_DIV-1, colS is captured as row r's bits. On the same edge d goes to 0 and r increments, wrapping 3 -> 0.
- The scan-end event is the edge where r == 3 and d == SCAN_DIV-1. The scan result uses rows 0-2 as captured plus the live colS for row 3:
  - exactly one low bit across all 16 gives key = r*4+c;
  - zero low bits gives NONE;
  - two or more low bits give NONE (ghost rejection).
- The debounce FSM updates only on scan-end events. It holds candidate cand and a 4-bit count n.
  - IDLE: a key k gives cand=k, n=1, go to CONFIRM. NONE stays in IDLE.
  - CONFIRM: result == cand gives n+1. When n+1 == DEBOUNCE_SCANS: KEYCODE=cand, KEY_VALID=1, KEY_DOWN=1, go to HELD. Any other result goes to IDLE.
  - HELD: result == cand stays. Anything else gives n=1, go to RELEASE.
  - RELEASE: result == cand goes back to HELD. Anything else gives n+1. When n+1 == DEBOUNCE_SCANS: KEY_DOWN=0, go to IDLE.
- KEY_VALID is set on acceptance and cleared on any edge with KEY_ACK=1. If both happen on the same edge, set wins.
- Acceptance while KEY_VALID=1 overwrites KEYCODE and pulses KEY_OVR for one cycle.
- A different key pressed during HELD/RELEASE is never accepted until the FSM returns to IDLE.

## Timing
- Reset values while rst=0: ROW=4'b1110, r=0, d=0, KEYCODE=0, KEY_VALID=0, KEY_DOWN=0, KEY_OVR=0, state IDLE, synchronizer=4'b1111.
- Reset is asynchronous: asserting rst mid-scan or mid-debounce forces these values immediately, with no clock edge.
- Row dwell is SCAN_DIV cycles and the scan period is 4*SCAN_DIV cycles. The first row change is SCAN_DIV edges after reset release.
- The sample taken at d == SCAN_DIV-1 reflects pins at d == SCAN_DIV-3 of the same row (2-cycle synchronizer), hence SCAN_DIV ≥ 4.
- Press latency: a key stable from before row 0 of a scan is accepted on the scan-end edge of its DEBOUNCE_SCANS-th scan. KEY_VALID, KEY_DOWN and KEYCODE change on that edge.
- Release latency: KEY_DOWN falls on the scan-end edge of the DEBOUNCE_SCANS-th consecutive non-matching scan.
- KEY_ACK is sampled every cycle. KEY_VALID falls the edge after KEY_ACK is seen high.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE_SCANS=3, scan = 16 cycles.
- Reset, then 32 idle cycles -> ROW runs 1110 ×4, 1101 ×4, 1011 ×4, 0111 ×4, repeating. All other outputs stay 0. Async reset asserted mid-row returns ROW=1110 with no clock.
- Key 6 model (COL[2] low whenever ROW[1]==0) held 5 scans -> at the 3rd scan-end: KEYCODE=6, KEY_VALID=1, KEY_DOWN=1. Pulse KEY_ACK for 1 cycle -> KEY_VALID=0 on the next edge. Release -> KEY_DOWN=0 at the 3rd NONE scan-end.
- Bounce: key 6 present 2 scans, absent 1, present 2, absent 3 -> KEY_VALID and KEY_DOWN never rise.
- Keys 0 and 15 held together for 5 scans -> no acceptance. Then release key 15 -> KEYCODE=0 accepted 3 scans later.
- No ACK after key 6; release for 3 scans; press key 9 (row 2, col 1) for 3 scans -> KEYCODE=9, KEY_VALID stays 1, KEY_OVR high exactly one cycle.
- Key 6 in HELD, rst pulsed low for 2 cycles -> KEY_DOWN=0 and KEY_VALID=0 immediately. With key still held after release of rst, re-acceptance occurs at the 3rd scan-end.
